// File: rtl/clock_divider_prog.sv
// Run-time programmable integer clock divider: produces a divided clock-like
// output and a one-cycle enable strobe per period, with glitch-free ratio reload.
module clock_divider_prog #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 8
) (
  input  logic             rst,
  input  logic             clk_high,
  input  logic             run,
  input  logic [CNT_W-1:0] div_num,
  input  logic             div_load,
  output logic             clk_low,
  output logic             enable,
  output logic             cfg_pending,
  output logic             active
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] div_act, div_act_nxt;
  logic [CNT_W-1:0] div_shd, div_shd_nxt;
  logic             pend_nxt;
  logic             clk_low_nxt;
  logic             enable_nxt;
  logic [CNT_W-1:0] div_req;
  logic             wrap;

  // Ratios below 2 cannot form a high and a low phase, so they run as 2.
  assign div_req = (div_num < DIV_MIN) ? DIV_MIN : div_num;
  assign wrap    = (state != IDLE) && (cnt == div_act - ONE);
  assign active  = (state != IDLE);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_nxt   = state;
    cnt_nxt     = cnt;
    div_act_nxt = div_act;
    div_shd_nxt = div_shd;
    pend_nxt    = cfg_pending;

    unique case (state)
      IDLE: begin
        if (run) state_nxt = RUN;
      end
      RUN: begin
        if (!run) state_nxt = STOPPING;
      end
      STOPPING: begin
        if (run)       state_nxt = RUN;
        else if (wrap) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (state == IDLE) begin
      cnt_nxt = '0;
      if (div_load) div_act_nxt = div_req;
    end else if (wrap) begin
      // Period boundary: a load on this very edge overrides any shadowed ratio.
      cnt_nxt  = '0;
      pend_nxt = 1'b0;
      if (div_load)         div_act_nxt = div_req;
      else if (cfg_pending) div_act_nxt = div_shd;
    end else begin
      cnt_nxt = cnt + ONE;
      if (div_load) begin
        div_shd_nxt = div_req;
        pend_nxt    = 1'b1;
      end
    end

    // Outputs look ahead at next-state values so they can be registered
    // without lagging the counter by a cycle.
    clk_low_nxt = (state_nxt != IDLE) && (cnt_nxt < (div_act_nxt >> 1));
    enable_nxt  = (state_nxt != IDLE) && (cnt_nxt == div_act_nxt - ONE);
  end

  always_ff @(posedge clk_high or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      div_act     <= DIV_RST;
      div_shd     <= '0;
      cfg_pending <= 1'b0;
      clk_low     <= 1'b0;
      enable      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      div_act     <= div_act_nxt;
      div_shd     <= div_shd_nxt;
      cfg_pending <= pend_nxt;
      clk_low     <= clk_low_nxt;
      enable      <= enable_nxt;
    end
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Self-checking bench for clock_divider_prog: directed scenarios followed by
// random traffic, compared every cycle against a period-level reference model.
module tb_clock_divider_prog;

  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 8;

  logic             rst;
  logic             clk_high;
  logic             run;
  logic [CNT_W-1:0] div_num;
  logic             div_load;
  logic             clk_low;
  logic             enable;
  logic             cfg_pending;
  logic             active;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: is a period in progress, position within it, its length,
  // a ratio waiting for the boundary (-1 = none), and whether a stop is requested.
  bit m_on;
  bit m_stop;
  int m_pos;
  int m_n;
  int m_pend;

  clock_divider_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .rst         (rst),
    .clk_high    (clk_high),
    .run         (run),
    .div_num     (div_num),
    .div_load    (div_load),
    .clk_low     (clk_low),
    .enable      (enable),
    .cfg_pending (cfg_pending),
    .active      (active)
  );

  initial clk_high = 1'b0;
  always #5 clk_high = ~clk_high;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_on   = 1'b0;
    m_stop = 1'b0;
    m_pos  = 0;
    m_n    = DEFAULT_DIV;
    m_pend = -1;
  endtask

  task automatic model_step();
    int req;
    req = (int'(div_num) < 2) ? 2 : int'(div_num);
    if (!m_on) begin
      if (div_load) m_n = req;
      if (run) begin
        m_on   = 1'b1;
        m_pos  = 0;
        m_stop = 1'b0;
      end
    end else if (m_pos == m_n - 1) begin
      m_pos = 0;
      if (div_load)         m_n = req;
      else if (m_pend >= 0) m_n = m_pend;
      m_pend = -1;
      if (m_stop && !run) m_on = 1'b0;
      m_stop = !run;
    end else begin
      m_pos++;
      if (div_load) m_pend = req;
      m_stop = !run;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".clk_low"},     clk_low,     m_on && (m_pos < m_n / 2));
    check({tag, ".enable"},      enable,      m_on && (m_pos == m_n - 1));
    check({tag, ".cfg_pending"}, cfg_pending, m_pend >= 0);
    check({tag, ".active"},      active,      m_on);
  endtask

  task automatic tick(input string tag);
    @(posedge clk_high);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  task automatic pulse_load(input int value, input string tag);
    div_num  = CNT_W'(value);
    div_load = 1'b1;
    tick(tag);
    div_load = 1'b0;
  endtask

  task automatic wait_pos(input int pos, input string tag);
    int budget;
    budget = 600;
    while (!(m_on && m_pos == pos) && budget > 0) begin
      tick(tag);
      budget--;
    end
    if (budget == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s.timeout: counter position %0d not reached", tag, pos);
    end
  endtask

  task automatic wait_idle(input string tag);
    int budget;
    budget = 600;
    while (m_on && budget > 0) begin
      tick(tag);
      budget--;
    end
    if (budget == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s.timeout: divider never stopped", tag);
    end
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b0;
    #1;
    check({tag, ".clk_low"},     clk_low,     1'b0);
    check({tag, ".enable"},      enable,      1'b0);
    check({tag, ".cfg_pending"}, cfg_pending, 1'b0);
    check({tag, ".active"},      active,      1'b0);
    model_reset();
    @(negedge clk_high);
    rst = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    run      = 1'b0;
    div_load = 1'b0;
    div_num  = '0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk_high);
    rst = 1'b1;
    tick("idle");

    // Default ratio after reset: 4 high / 4 low, enable at position 7.
    run = 1'b1;
    repeat (20) tick("default_div");

    // Mid-period load shadows the ratio until the wrap.
    wait_pos(2, "load_mid");
    pulse_load(5, "load_mid");
    repeat (16) tick("load_mid_after");

    // Load on the wrap edge applies to the period starting there.
    wait_pos(4, "load_wrap");
    pulse_load(6, "load_wrap");
    repeat (14) tick("load_wrap_after");

    // Ratios 0 and 1 loaded in IDLE clamp to 2.
    run = 1'b0;
    wait_idle("stop_for_clamp");
    pulse_load(0, "clamp0");
    pulse_load(1, "clamp1");
    run = 1'b1;
    repeat (10) tick("clamp_run");

    // Graceful stop at N = 8, then resume from a STOPPING period.
    pulse_load(8, "reload8");
    wait_pos(0, "reload8_wrap");
    wait_pos(3, "stop_at3");
    run = 1'b0;
    repeat (7) tick("stopping");
    run = 1'b1;
    wait_pos(2, "restart");
    run = 1'b0;
    wait_pos(5, "resume");
    run = 1'b1;
    repeat (12) tick("resume_run");

    // Asynchronous reset mid-period at N = 5 with a pending load.
    pulse_load(5, "reload5");
    wait_pos(0, "reload5_wrap");
    wait_pos(2, "pre_reset");
    pulse_load(3, "pending_before_reset");
    async_reset("rst_mid");
    repeat (20) tick("post_reset");

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      run      = ($urandom_range(0, 9) != 0);
      div_load = ($urandom_range(0, 7) == 0);
      div_num  = ($urandom_range(0, 19) == 0) ? CNT_W'($urandom_range(0, 40))
                                              : CNT_W'($urandom_range(0, 12));
      if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
      else tick("random");
    end
    div_load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Parametrised, run-time programmable integer clock divider for the receive datapath.
- Derives a divided clock-like signal clk_low and a one-cycle enable strobe from clk_high.
- Division ratio is reloadable on the fly. A new ratio takes effect glitch-free at a period boundary.
- Supports start/stop control with graceful completion of the current period.

Parameters:
- CNT_W, 8, width of the division ratio and of the internal counter.
- DEFAULT_DIV, 8, ratio used after reset until the first load (must be >= 2).

Ports:
- rst  input  1  asynchronous active-low reset
- clk_high  input  1  source clock; all logic on its rising edge
- run  input  1  1 = generate output periods; 0 = stop after the current period
- div_num  input  CNT_W  requested division ratio N; values 0 and 1 are clamped to 2
- div_load  input  1  one-cycle request to capture div_num
- clk_low  output  1  divided output; high for floor(N/2) cycles, low for the remaining cycles of each period
- enable  output  1  one-cycle strobe in the last clk_high cycle of each period
- cfg_pending  output  1  captured ratio is waiting for a period boundary
- active  output  1  divider is in RUN or STOPPING

Behaviour:
- Reset is async on rst low:
  - state = IDLE, counter = 0, active ratio = DEFAULT_DIV, shadow = 0.
  - cfg_pending = 0, clk_low = 0, enable = 0, active = 0.
- States: IDLE, RUN, STOPPING.
  - IDLE: run = 1 → RUN.
  - RUN: run = 0 → STOPPING.
  - STOPPING: run = 1 → RUN, with no gap and no counter disturbance. Counter wrap with run = 0 → IDLE.
- Counter:
  - Counts 0..N-1 in RUN and STOPPING. Wraps to 0 after N-1.
  - Held at 0 in IDLE.
  - Width is CNT_W, so the maximum ratio is 2^CNT_W-1.
- Outputs are registered. They are computed from next-state and next-counter values, so on every cycle:
  - clk_low = (state != IDLE) and (counter < N/2)
  - enable = (state != IDLE) and (counter == N-1)
  - No combinational paths from inputs to outputs.
- Start latency: the edge that samples run = 1 in IDLE makes counter = 0 and clk_low = 1 on that same edge. The first enable occurs N-1 cycles later.
- Ratio load:
  - div_load in IDLE: the clamped ratio becomes active immediately. cfg_pending stays 0.
  - div_load in RUN/STOPPING: the clamped ratio goes into the shadow register and cfg_pending = 1. It is copied to the active ratio on the wrap edge (counter N-1 → 0), and cfg_pending clears on that edge.
  - div_load on the same edge as a wrap: the new value applies directly to the period starting on that edge (bypass). cfg_pending stays 0.
  - Repeated loads before a boundary: the last value wins.
- Stop: the STOPPING period completes in full, including its enable strobe. On the wrap edge, state = IDLE, clk_low = 0, active = 0. A pending ratio is applied on that edge.
- N = 2: clk_low toggles every cycle and enable is high every other cycle. N = 3: clk_low is high 1 cycle, low 2 cycles.
- Reset mid-operation: all outputs return to their reset values immediately. The ratio reverts to DEFAULT_DIV.

Test Plan:
1. Reset, run = 1, no load → clk_low is high 4 / low 4 cycles repeating. enable pulses in cycle 7 of each period, period 8. active = 1.
2. Running at N = 8, div_num = 5 with div_load at counter = 2 → cfg_pending = 1 until the wrap. The current period stays 8 cycles, the next periods are 5 cycles (high 2 / low 3). cfg_pending clears at the wrap.
3. div_load with div_num = 6 exactly on the wrap edge → the period starting on that edge is 6 cycles long. cfg_pending never asserts.
4. div_num = 0, then 1, loaded in IDLE, then run → behaves as N = 2: clk_low alternates 1,0 and enable is high on every second cycle.
5. run dropped at counter = 3 (N = 8) → 4 more cycles, including the enable at counter 7. Then clk_low = 0 and active = 0. Re-asserting run at counter 5 of a later STOPPING period keeps running with no gap.
6. rst pulsed low mid-period at N = 5 → clk_low, enable, cfg_pending and active go to 0 asynchronously. After release with run = 1, the period is 8 (DEFAULT_DIV).
